// File: rtl/alu_if.sv
// ALU operand/result bundle between the execute stage and the ALU.
interface alu_if;
   logic [31:0] i_op_a;
   logic [31:0] i_op_b;
   logic [3:0]  i_alu_op;
   logic [31:0] o_alu_data;

   // Execute stage drives operands and opcode, reads back the result.
   modport master (
      output i_op_a,
      output i_op_b,
      output i_alu_op,
      input  o_alu_data
   );

   // ALU consumes operands and opcode, returns the registered result.
   modport slave (
      input  i_op_a,
      input  i_op_b,
      input  i_alu_op,
      output o_alu_data
   );
endinterface

// File: rtl/alu.sv
// RV32I integer ALU: ten ops selected by {funct7[5], funct3}, result
// registered once. Everything ahead of the output flop is combinational.
module alu (
   input  logic i_clk,
   input  logic i_rst_n,
   alu_if.slave bus
);

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111,
      OP_SUB  = 4'b1000,
      OP_SRA  = 4'b1101
   } alu_op_e;

   localparam int W      = 32;
   localparam int SH_W   = 5;

   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   alu_op_e       op;

   assign op_a = bus.i_op_a;
   assign op_b = bus.i_op_b;
   assign op   = alu_op_e'(bus.i_alu_op);

   // ------------------------------------------------------------------
   // Add / subtract. The subtract is 33 bits wide so the borrow and the
   // sign of the true difference are both available for the compares.
   // ------------------------------------------------------------------
   logic [W-1:0]  sum_w;
   logic [W:0]    sub_w;
   logic [W-1:0]  diff_w;
   logic          borrow_w;
   logic          ovf_w;
   logic          slt_w;
   logic          sltu_w;

   assign sum_w    = op_a + op_b;
   assign sub_w    = {1'b0, op_a} - {1'b0, op_b};
   assign diff_w   = sub_w[W-1:0];
   assign borrow_w = sub_w[W];

   // Signed overflow on a-b: operands differ in sign and the result sign
   // does not match a. The true sign of a-b is then the inverse of diff[31].
   assign ovf_w  = (op_a[W-1] ^ op_b[W-1]) & (diff_w[W-1] ^ op_a[W-1]);
   assign slt_w  = diff_w[W-1] ^ ovf_w;
   assign sltu_w = borrow_w;

   // ------------------------------------------------------------------
   // Shifter. One logarithmic right shifter serves all three shifts;
   // left shift runs it on the bit-reversed operand and reverses back.
   // Only b[4:0] is used as the shift amount.
   // ------------------------------------------------------------------
   logic [SH_W-1:0] shamt_w;
   logic            is_sll_w;
   logic            fill_w;
   logic [W-1:0]    a_rev_w;
   logic [W-1:0]    sh_src_w;
   logic [W-1:0]    sh_out_w;
   logic [W-1:0]    sh_out_rev_w;
   logic [W-1:0]    stg_w [0:SH_W];

   assign shamt_w  = op_b[SH_W-1:0];
   assign is_sll_w = (op == OP_SLL);
   // Sign fill only for SRA; SLL and SRL shift in zeros.
   assign fill_w   = (op == OP_SRA) & op_a[W-1];

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_rev
         assign a_rev_w[gi]      = op_a[W-1-gi];
         assign sh_out_rev_w[gi] = sh_out_w[W-1-gi];
      end
   endgenerate

   assign sh_src_w = is_sll_w ? a_rev_w : op_a;
   assign stg_w[0] = sh_src_w;

   genvar gk;
   generate
      for (gk = 0; gk < SH_W; gk++) begin : g_stage
         localparam int S = 1 << gk;
         assign stg_w[gk+1] = shamt_w[gk] ? {{S{fill_w}}, stg_w[gk][W-1:S]}
                                           : stg_w[gk];
      end
   endgenerate

   assign sh_out_w = stg_w[SH_W];

   // ------------------------------------------------------------------
   // Result select and output register.
   // ------------------------------------------------------------------
   logic [W-1:0] res_d;
   logic [W-1:0] res_q;

   // Pick the result for the current opcode; unused encodings give zero.
   always_comb begin
      res_d = '0;
      case (op)
         OP_ADD:  res_d = sum_w;
         OP_SUB:  res_d = diff_w;
         OP_SLL:  res_d = sh_out_rev_w;
         OP_SLT:  res_d = {{(W-1){1'b0}}, slt_w};
         OP_SLTU: res_d = {{(W-1){1'b0}}, sltu_w};
         OP_XOR:  res_d = op_a ^ op_b;
         OP_SRL:  res_d = sh_out_w;
         OP_SRA:  res_d = sh_out_w;
         OP_OR:   res_d = op_a | op_b;
         OP_AND:  res_d = op_a & op_b;
         default: res_d = '0;
      endcase
   end

   // Capture the result every cycle; reset clears it and drops any op in flight.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) res_q <= '0;
      else          res_q <= res_d;
   end

   assign bus.o_alu_data = res_q;

endmodule

// File: tb/tb_alu.sv
// Bench for the RV32I ALU: directed corner cases plus a random stream,
// all checked against a plain-arithmetic reference model.
module tb_alu;

   logic clk;
   logic rst_n;
   alu_if bus ();

   alu dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_mis = 0;
   bit chk_en = 1'b0;

   // Reference: result of one op straight from the RV32I definitions.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [31:0] r;
      int unsigned sh;
      sa = a;
      sb = b;
      sh = 32'(b[4:0]);
      case (op)
         4'b0000: r = a + b;
         4'b1000: r = a - b;
         4'b0001: r = a << sh;
         4'b0010: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b0011: r = (a < b) ? 32'd1 : 32'd0;
         4'b0100: r = a ^ b;
         4'b0101: r = a >> sh;
         4'b1101: r = sa >>> sh;
         4'b0110: r = a | b;
         4'b0111: r = a & b;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %08h want %08h", name, act, req);
      end
   endtask

   // Expected output register: what the ALU must show after each edge.
   logic [31:0] exp_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_q <= 32'h0;
      else        exp_q <= model(bus.i_op_a, bus.i_op_b, bus.i_alu_op);
   end

   // Every cycle, away from the active edge, compare DUT against the model.
   always @(negedge clk) begin
      if (chk_en) check("stream", bus.o_alu_data, exp_q);
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
      bus.i_op_a   = a;
      bus.i_op_b   = b;
      bus.i_alu_op = op;
   endtask

   // Directed op with hand-computed result, checked one edge later.
   task automatic dir(input string name, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [31:0] e);
      @(negedge clk);
      drive(a, b, op);
      @(posedge clk);
      #1;
      check(name, bus.o_alu_data, e);
   endtask

   function automatic logic [31:0] rnd_operand();
      logic [31:0] c [5];
      c[0] = 32'h0; c[1] = 32'h1; c[2] = 32'h7FFFFFFF;
      c[3] = 32'h80000000; c[4] = 32'hFFFFFFFF;
      if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      drive(32'hDEADBEEF, 32'h12345678, 4'b0000);
      #1 rst_n = 1'b0;
      drive($urandom, $urandom, 4'($urandom));
      #2;
      check("reset_async", bus.o_alu_data, 32'h0);
      chk_en = 1'b1;

      // Hold reset across edges with changing inputs; output stays zero.
      repeat (3) begin
         @(negedge clk);
         drive($urandom, $urandom, 4'($urandom));
         @(posedge clk);
         #1;
         check("reset_hold", bus.o_alu_data, 32'h0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Pin the reference model itself on the subtle cases.
      check("model_slt_bnd",  model(32'h7FFFFFFF, 32'h80000000, 4'b0010), 32'h0);
      check("model_sltu_bnd", model(32'h7FFFFFFF, 32'h80000000, 4'b0011), 32'h1);
      check("model_sra_neg",  model(32'hFFFFFC00, 32'd10, 4'b1101), 32'hFFFFFFFF);
      check("model_sll_b21",  model(32'h1, 32'h21, 4'b0001), 32'h2);
      check("model_illegal",  model(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010), 32'h0);

      dir("add_5_10",       32'd5,        32'd10,       4'b0000, 32'd15);
      dir("add_wrap_max",   32'h7FFFFFFF, 32'h1,        4'b0000, 32'h80000000);
      dir("add_wrap_all1",  32'hFFFFFFFF, 32'h1,        4'b0000, 32'h0);
      dir("add_min_min",    32'h80000000, 32'h80000000, 4'b0000, 32'h0);
      dir("sub_0_1",        32'h0,        32'h1,        4'b1000, 32'hFFFFFFFF);
      dir("sub_min_1",      32'h80000000, 32'h1,        4'b1000, 32'h7FFFFFFF);
      dir("slt_m5_5",       32'hFFFFFFFB, 32'd5,        4'b0010, 32'h1);
      dir("slt_max_min",    32'h7FFFFFFF, 32'h80000000, 4'b0010, 32'h0);
      dir("slt_min_0",      32'h80000000, 32'h0,        4'b0010, 32'h1);
      dir("sltu_max_min",   32'h7FFFFFFF, 32'h80000000, 4'b0011, 32'h1);
      dir("sltu_all1_0",    32'hFFFFFFFF, 32'h0,        4'b0011, 32'h0);
      dir("sltu_0_all1",    32'h0,        32'hFFFFFFFF, 4'b0011, 32'h1);
      dir("sll_1_31",       32'h1,        32'd31,       4'b0001, 32'h80000000);
      dir("sll_8",          32'h12345678, 32'd8,        4'b0001, 32'h34567800);
      dir("srl_31",         32'hFFFFFFFF, 32'd31,       4'b0101, 32'h1);
      dir("sra_m1024_10",   32'hFFFFFC00, 32'd10,       4'b1101, 32'hFFFFFFFF);
      dir("sra_min_31",     32'h80000000, 32'd31,       4'b1101, 32'hFFFFFFFF);
      dir("sra_max_31",     32'h7FFFFFFF, 32'd31,       4'b1101, 32'h0);
      dir("sll_b21",        32'h1,        32'h21,       4'b0001, 32'h2);
      dir("sll_0",          32'hA5A5A5A5, 32'hFFFFFFE0, 4'b0001, 32'hA5A5A5A5);
      dir("sra_0",          32'h80000001, 32'h0,        4'b1101, 32'h80000001);
      dir("and_8_3",        32'd8,        32'd3,        4'b0111, 32'h0);
      dir("xor_aa_55",      32'hAAAAAAAA, 32'h55555555, 4'b0100, 32'hFFFFFFFF);
      dir("or_0_0",         32'h0,        32'h0,        4'b0110, 32'h0);
      dir("illegal_1111",   32'hFFFFFFFF, 32'h1,        4'b1111, 32'h0);
      dir("illegal_1001",   32'h12345678, 32'h1,        4'b1001, 32'h0);

      // Random stream, new op every cycle; the compare process checks each one.
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         drive(rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
      end

      // Reset in the middle of the stream discards the op in flight.
      @(negedge clk);
      drive(32'h11111111, 32'h22222222, 4'b0000);
      #2 rst_n = 1'b0;
      #1;
      check("reset_midstream", bus.o_alu_data, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_first", bus.o_alu_data, 32'h33333333);

      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         drive(rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
